// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the loadable instruction memory:
//   - state_e        : controller states (RUN, LOAD, RESUME)
//   - NOP_WORD_DEFAULT: word presented whenever no real instruction is valid
//   - imemClog2      : address-width helper (ceil(log2(value)))
// ---------------------------------------------------------------------------
package imem_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LOAD   = 2'd1,
      RESUME = 2'd2
   } state_e;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   // Smallest n with 2**n >= value; used to size word indices
   function automatic int imemClog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// ---------------------------------------------------------------------------
// imem_ram_1r1w
// DEPTH x DATA_W RAM with one synchronous write port and one synchronous
// read port. No reset: contents persist across controller resets.
// The read data register only updates when re_i is high, so the last word
// read stays on rdata_o while the pipeline is stalled or idle.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read word index
//   rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module imem_ram_1r1w
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int AW     = imemClog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write port and registered read port share the clock; the controller
   // never enables both on the same cycle, so ordering does not matter
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_sync_loadable.sv
// ---------------------------------------------------------------------------
// imem_sync_loadable
// Run-time loadable, synchronous-read instruction memory for the IF stage.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   pc         in   fetch byte address
//   fetch_en   in   fetch request this cycle
//   stall      in   hold IF output
//   flush      in   kill IF output
//   inst       out  instruction (one cycle after pc)
//   inst_valid out  inst is a real fetched word (or a faulting fetch)
//   fault      out  fetch for the current inst was misaligned/out of range
//   ld_en      in   write ld_data to ld_addr this cycle
//   ld_addr    in   word index to load
//   ld_data    in   word to load
//   busy       out  controller is not in RUN
//   ld_count   out  words written in the current load session (saturating)
// ---------------------------------------------------------------------------
module imem_sync_loadable
   import imem_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                PC_W     = 32,
   parameter int                DEPTH    = 64,
   parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEFAULT,
   localparam int               AW       = imemClog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   pc,
   input  logic              fetch_en,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] inst,
   output logic              inst_valid,
   output logic              fault,
   input  logic              ld_en,
   input  logic [AW-1:0]     ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              busy,
   output logic [AW:0]       ld_count
);

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              inst_valid_q, inst_valid_d;
   logic              fault_q, fault_d;
   logic              from_ram_q, from_ram_d;
   logic [AW:0]       ld_count_q, ld_count_d;

   logic              ram_we, ram_re;
   logic [DATA_W-1:0] ram_rdata;
   logic [AW-1:0]     fetch_index;
   logic              misaligned, out_of_range, addr_fault;

   // Byte address decode: word index, alignment and range checks
   assign fetch_index  = pc[2 +: AW];
   assign misaligned   = (pc[1:0] != 2'b00);
   assign out_of_range = |pc[PC_W-1:AW+2];
   assign addr_fault   = misaligned | out_of_range;

   // Next-state logic. from_ram_d selects whether inst shows the RAM read
   // register or NOP_WORD; since the RAM only reads on ram_re, holding
   // from_ram_q holds inst for stall and idle cycles.
   always_comb begin
      state_d      = state_q;
      inst_valid_d = inst_valid_q;
      fault_d      = fault_q;
      from_ram_d   = from_ram_q;
      ld_count_d   = ld_count_q;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      unique case (state_q)
         RUN: begin
            if (ld_en) begin
               ram_we       = 1'b1;
               state_d      = LOAD;
               ld_count_d   = (AW+1)'(1);
               inst_valid_d = 1'b0;
               fault_d      = 1'b0;
               from_ram_d   = 1'b0;
            end else if (flush) begin
               inst_valid_d = 1'b0;
               fault_d      = 1'b0;
               from_ram_d   = 1'b0;
            end else if (stall) begin
               inst_valid_d = inst_valid_q;
            end else if (fetch_en) begin
               inst_valid_d = 1'b1;
               if (addr_fault) begin
                  fault_d    = 1'b1;
                  from_ram_d = 1'b0;
               end else begin
                  ram_re     = 1'b1;
                  fault_d    = 1'b0;
                  from_ram_d = 1'b1;
               end
            end else begin
               inst_valid_d = 1'b0;
               fault_d      = 1'b0;
            end
         end
         LOAD: begin
            inst_valid_d = 1'b0;
            fault_d      = 1'b0;
            from_ram_d   = 1'b0;
            if (ld_en) begin
               ram_we = 1'b1;
               if (ld_count_q != (AW+1)'(DEPTH)) begin
                  ld_count_d = ld_count_q + 1'b1;
               end
            end else begin
               state_d = RESUME;
            end
         end
         RESUME: begin
            inst_valid_d = 1'b0;
            fault_d      = 1'b0;
            from_ram_d   = 1'b0;
            state_d      = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      busy_d = (state_d != RUN);
   end

   // Controller and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         busy_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
         from_ram_q   <= 1'b0;
         ld_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         inst_valid_q <= inst_valid_d;
         fault_q      <= fault_d;
         from_ram_q   <= from_ram_d;
         ld_count_q   <= ld_count_d;
      end
   end

   // The RAM has no reset, so a write must be blocked while rst is held or
   // a word presented during reset would land in memory
   imem_ram_1r1w #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we & ~rst),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .re_i    (ram_re & ~rst),
      .raddr_i (fetch_index),
      .rdata_o (ram_rdata)
   );

   assign inst       = from_ram_q ? ram_rdata : NOP_WORD;
   assign inst_valid = inst_valid_q;
   assign fault      = fault_q;
   assign busy       = busy_q;
   assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_imem_sync_loadable.sv
// ---------------------------------------------------------------------------
// tb_imem_sync_loadable
// Directed stimulus for imem_sync_loadable with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_imem_sync_loadable;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        fetch_en;
   logic        stall;
   logic        flush;
   logic [31:0] inst;
   logic        inst_valid;
   logic        fault;
   logic        ld_en;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;
   logic        busy;
   logic [6:0]  ld_count;

   int checks;
   int errors;

   imem_sync_loadable #(
      .DATA_W   (32),
      .PC_W     (32),
      .DEPTH    (64),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .fetch_en   (fetch_en),
      .stall      (stall),
      .flush      (flush),
      .inst       (inst),
      .inst_valid (inst_valid),
      .fault      (fault),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .busy       (busy),
      .ld_count   (ld_count)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then sample 1 ns after the rising edge
   task automatic applyStimulus(input logic [31:0] pcV, input logic feV,
                                input logic stV, input logic flV,
                                input logic ldV, input logic [5:0] addrV,
                                input logic [31:0] dataV);
      pc       = pcV;
      fetch_en = feV;
      stall    = stV;
      flush    = flV;
      ld_en    = ldV;
      ld_addr  = addrV;
      ld_data  = dataV;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic checkFetch(input string tag, input logic [31:0] expInst,
                             input logic expValid, input logic expFault);
      checkOutput({tag, ".inst"}, inst, expInst);
      checkOutput({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, expValid});
      checkOutput({tag, ".fault"}, {31'd0, fault}, {31'd0, expFault});
   endtask

   task automatic checkCtrl(input string tag, input logic expBusy,
                            input logic [6:0] expCount);
      checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, expBusy});
      checkOutput({tag, ".ld_count"}, {25'd0, ld_count}, {25'd0, expCount});
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      pc       = '0;
      fetch_en = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      ld_en    = 1'b0;
      ld_addr  = '0;
      ld_data  = '0;

      // Reset state
      #12;
      checkFetch("reset", 32'h0, 1'b0, 1'b0);
      checkCtrl("reset", 1'b0, 7'd0);
      rst = 1'b0;

      // Two-word load then idle: busy for three cycles
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 32'h2002_0005);
      checkCtrl("load0", 1'b1, 7'd1);
      checkFetch("load0", 32'h0, 1'b0, 1'b0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 32'h2007_0003);
      checkCtrl("load1", 1'b1, 7'd2);
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkCtrl("resume", 1'b1, 7'd2);
      checkFetch("resume", 32'h0, 1'b0, 1'b0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 32'hBAD0_BAD0);
      checkCtrl("backToRun", 1'b0, 7'd2);

      // Legal fetches, one-cycle latency
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("fetchPc0", 32'h2002_0005, 1'b1, 1'b0);
      applyStimulus(32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("fetchPc4", 32'h2007_0003, 1'b1, 1'b0);

      // Misaligned and out-of-range fetches
      applyStimulus(32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("misaligned", 32'h0, 1'b1, 1'b1);
      applyStimulus(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("outOfRange", 32'h0, 1'b1, 1'b1);

      // Word 5 was offered in RESUME and must not have been written
      applyStimulus(32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkOutput("resumeNoWrite", inst === 32'hBAD0_BAD0 ? 32'h1 : 32'h0, 32'h0);

      // Idle cycle: valid drops, inst holds
      applyStimulus(32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("idleHold", 32'h2007_0003, 1'b0, 1'b0);

      // Stall for three cycles with changing pc
      applyStimulus(32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("preStall", 32'h2007_0003, 1'b1, 1'b0);
      applyStimulus(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("stall1", 32'h2007_0003, 1'b1, 1'b0);
      applyStimulus(32'h2, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("stall2", 32'h2007_0003, 1'b1, 1'b0);
      applyStimulus(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("stall3", 32'h2007_0003, 1'b1, 1'b0);
      applyStimulus(32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
      checkFetch("flushBeatsStall", 32'h0, 1'b0, 1'b0);

      // Load preempts a fetch in the same RUN cycle
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("refetchPc0", 32'h2002_0005, 1'b1, 1'b0);
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 32'hDEAD_BEEF);
      checkFetch("loadPreempts", 32'h0, 1'b0, 1'b0);
      checkCtrl("loadPreempts", 1'b1, 7'd1);
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0);
      checkCtrl("resume2", 1'b1, 7'd1);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkCtrl("run2", 1'b0, 7'd1);
      applyStimulus(32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("fetchPc8", 32'hDEAD_BEEF, 1'b1, 1'b0);

      // Reset arrives while the third of five words is presented
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 32'h1111_0000);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 32'h1111_0001);
      checkCtrl("midLoad", 1'b1, 7'd2);
      ld_addr = 6'd2;
      ld_data = 32'h1111_0002;
      #2;
      rst = 1'b1;
      #1;
      checkFetch("asyncReset", 32'h0, 1'b0, 1'b0);
      checkCtrl("asyncReset", 1'b0, 7'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      ld_en = 1'b0;
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("afterReset0", 32'h1111_0000, 1'b1, 1'b0);
      checkCtrl("afterReset", 1'b0, 7'd0);
      applyStimulus(32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("afterReset1", 32'h1111_0001, 1'b1, 1'b0);
      applyStimulus(32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("afterReset2", 32'hDEAD_BEEF, 1'b1, 1'b0);

      // 65-word session: ld_count saturates at DEPTH, index wraps to 0
      for (int i = 0; i < 65; i++) begin
         applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'(i), 32'hA000_0000 + 32'(i));
         if (i == 62) begin
            checkCtrl("count63", 1'b1, 7'd63);
         end
      end
      checkCtrl("countSat", 1'b1, 7'd64);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkCtrl("countHold", 1'b0, 7'd64);
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("wrapWord0", 32'hA000_0040, 1'b1, 1'b0);
      applyStimulus(32'hFC, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      checkFetch("lastWord", 32'hA000_003F, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_sync_loadable.md
Name: imem_sync_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the 32-bit pipeline IF stage.
- Replaces a fixed combinational program table with a RAM that:
  - is loaded at run time through a word-write port;
  - returns instructions one cycle after the PC is presented;
  - supports pipeline stall and flush;
  - flags misaligned or out-of-range fetches.

Parameters:
- DATA_W, 32, instruction width.
- PC_W, 32, PC width (byte address).
- DEPTH, 64, number of instruction words; power of two, at least 2.
- NOP_WORD, 32'h00000000, word driven on flush, fault, reset and busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pc  in  PC_W  fetch byte address.
- fetch_en  in  1  fetch request this cycle.
- stall  in  1  hold IF output.
- flush  in  1  kill IF output.
- inst  out  DATA_W  registered instruction.
- inst_valid  out  1  inst is a real fetched word.
- fault  out  1  the fetch for the current inst was misaligned or out of range.
- ld_en  in  1  write ld_data to ld_addr this cycle.
- ld_addr  in  AW  word index, where AW = clog2(DEPTH).
- ld_data  in  DATA_W  word to write.
- busy  out  1  state is not RUN.
- ld_count  out  AW+1  words written in the current load session (saturating).

Behaviour:
- **Reset (asynchronous, any state):**
  - inst=NOP_WORD, inst_valid=0, fault=0, busy=0, ld_count=0, state=RUN.
  - RAM contents are NOT cleared; words loaded before reset survive it.
- **Address decode:**
  - index = pc[2 +: AW].
  - Misaligned: pc[1:0]!=0.
  - Out of range: any pc bit above bit AW+1 set.
- **States:** RUN, LOAD, RESUME.
- **RUN:**
  - ld_en=1: write RAM[ld_addr]=ld_data, go to LOAD, ld_count<=1. Any fetch that cycle is dropped; next inst=NOP_WORD, inst_valid=0.
  - Otherwise apply the first matching rule, in priority order:
    1. flush=1: next inst=NOP_WORD, inst_valid=0, fault=0. Flush beats stall.
    2. stall=1: inst, inst_valid, fault hold their values.
    3. fetch_en=1 and decode fault: next inst=NOP_WORD, inst_valid=1, fault=1. RAM is not read.
    4. fetch_en=1, legal address: next inst=RAM[index], inst_valid=1, fault=0. Latency is exactly 1 cycle.
    5. fetch_en=0: next inst_valid=0, fault=0; inst holds its value.
- **LOAD:**
  - ld_en=1: write the word; ld_count increments, saturating at DEPTH.
  - ld_en=0: go to RESUME.
  - fetch_en, stall and flush are ignored; inst=NOP_WORD, inst_valid=0, fault=0.
- **RESUME:**
  - One cycle with outputs as in LOAD, then RUN.
  - ld_en=1 in RESUME is ignored (no write); the loader must wait for busy=0.
- **Read/write interaction:** a same-address read and write can never occur in one cycle, because load preempts fetch; read-during-write behaviour is therefore unconstrained.
- **ld_count:** cleared only by reset or by the next RUN to LOAD entry; holds its value in RESUME and RUN.
- **busy:** registered; equals (state!=RUN).
- **Widths:** ld_addr is AW bits, so every address is in range; no ld fault exists.
- **Reset mid-LOAD:** words already written are retained; the word presented in the reset cycle is not written.

Decomposition:
- Shared package imem_pkg holds:
  - the state enum {RUN, LOAD, RESUME};
  - the NOP_WORD default;
  - an AW helper function (clog2).
- One natural sub-module, imem_ram_1r1w: synchronous-read, synchronous-write RAM of DEPTH x DATA_W with no reset.
- The controller FSM, address decode and output register live in the top level.

Test Plan:
- Load RAM[0]=32'h20020005 and RAM[1]=32'h20070003 over 2 ld_en cycles, then idle.
  - busy is high for 3 cycles, ld_count=2.
  - fetch pc=0x0 gives inst=32'h20020005 next cycle; pc=0x4 gives 32'h20070003; inst_valid=1.
- Fetch pc=0x2.
  - Next cycle: inst=0, inst_valid=1, fault=1.
- Fetch pc=0x100 (index 64, DEPTH=64).
  - fault=1, inst=0.
- Fetch pc=0x4, then stall=1 for 3 cycles with pc changing.
  - inst stays 32'h20070003 with inst_valid=1.
  - Assert flush and stall together: next inst=0, inst_valid=0.
- ld_en=1 with fetch_en=1 in the same RUN cycle.
  - The write occurs, the fetch is dropped, inst_valid=0, busy=1 next cycle.
- Reset asserted during the 3rd word of a 5-word load.
  - Outputs and ld_count reset immediately; state is RUN.
  - Afterwards: words 0-1 read back correct; word 2 reads its old value.
